instruction_prefetch_queue: RTL and testbench

Fetch-side block upstream of the IF/ID pipeline register. It replaces the zero-latency instruction memory path with a variable-latency request/acknowledge memory port. It prefetches sequential words into a small FIFO and presents the head instruction with its PC+4 to the IF/ID register. It honours the hazard unit's hold and discards all queued and in-flight fetches on a branch redirect.

---
 rtl/instruction_prefetch_queue_if.sv | 33 +++
 rtl/instruction_prefetch_queue.sv | 140 ++++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_queue_if.sv
// Bundles the instruction-memory port and the IF/ID-facing signals of the
// prefetch queue. The queue itself uses the master view; the memory model
// and the fetch/hazard side use the slave view.
interface instruction_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    // Instruction memory request/acknowledge port
    logic                    memReq;
    logic [31:0]             memAddr;
    logic                    memAck;
    logic [31:0]             memData;

    // Hazard unit and branch resolution controls
    logic                    hold;
    logic                    redirect;
    logic [31:0]             redirectAddr;

    // Head of the queue as seen by the IF/ID register
    logic                    instrValid;
    logic [31:0]             instruction;
    logic [31:0]             pcPlus4;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output memReq, memAddr, instrValid, instruction, pcPlus4, count,
        input  memAck, memData, hold, redirect, redirectAddr
    );

    modport slave (
        input  memReq, memAddr, instrValid, instruction, pcPlus4, count,
        output memAck, memData, hold, redirect, redirectAddr
    );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher sitting in front of the IF/ID register.
// Issues word fetches over a request/acknowledge memory port, buffers the
// returned words in a small FIFO together with their PC+4, and presents the
// head entry combinationally. A branch redirect flushes the FIFO and turns any
// outstanding fetch into a discarded one so stale words never reach decode.
module instruction_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    instruction_prefetch_queue_if.master bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Fetch controller states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetchPC_q, fetchPC_d;
    logic [31:0]   memAddr_q, memAddr_d;
    logic          memReq_q;
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] countNext;
    logic [31:0]   instrMem_q [DEPTH];
    logic [31:0]   pcMem_q    [DEPTH];

    logic          push;
    logic          pop;
    logic          headValid;
    logic [31:0]   addrPlus4;

    assign headValid = (count_q != '0);
    assign addrPlus4 = memAddr_q + 32'd4;

    // A returned word is only kept when the fetch was a live one and no
    // redirect arrives in the same cycle; redirect also suppresses the pop.
    assign push = (state_q == REQ) && bus.memAck && !bus.redirect;
    assign pop  = headValid && !bus.hold && !bus.redirect;

    // Occupancy after this cycle's push and pop, before any flush
    always_comb begin
        countNext = count_q;
        if (push && !pop) begin
            countNext = count_q + CW'(1);
        end else if (pop && !push) begin
            countNext = count_q - CW'(1);
        end
        count_d = bus.redirect ? '0 : countNext;
    end

    // Fetch FSM: decides the next request address and whether to keep fetching
    always_comb begin
        state_d   = state_q;
        memAddr_d = memAddr_q;
        fetchPC_d = fetchPC_q;
        case (state_q)
            IDLE: begin
                if (!bus.redirect && (countNext < FULL)) begin
                    state_d   = REQ;
                    memAddr_d = fetchPC_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    state_d = bus.memAck ? IDLE : DISCARD;
                end else if (bus.memAck) begin
                    fetchPC_d = addrPlus4;
                    if (countNext < FULL) begin
                        memAddr_d = addrPlus4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (bus.memAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.redirect) begin
            fetchPC_d = {bus.redirectAddr[31:2], 2'b00};
        end
    end

    // Control state, request port and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fetchPC_q <= RESET_PC;
            memAddr_q <= RESET_PC;
            memReq_q  <= 1'b0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPC_q <= fetchPC_d;
            memAddr_q <= memAddr_d;
            memReq_q  <= (state_d != IDLE);
            count_q   <= count_d;
            if (bus.redirect) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
            end else begin
                if (push) begin
                    wrPtr_q <= wrPtr_q + PW'(1);
                end
                if (pop) begin
                    rdPtr_q <= rdPtr_q + PW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are only ever read while the entry is occupied
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem_q[wrPtr_q] <= bus.memData;
            pcMem_q[wrPtr_q]    <= addrPlus4;
        end
    end

    assign bus.memReq      = memReq_q;
    assign bus.memAddr     = memAddr_q;
    assign bus.count       = count_q;
    assign bus.instrValid  = headValid;
    assign bus.instruction = headValid ? instrMem_q[rdPtr_q] : 32'h0;
    assign bus.pcPlus4     = headValid ? pcMem_q[rdPtr_q] : 32'h0;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with DEPTH=4 and RESET_PC=0.
// The memory returns (32'hC0DE_0000 ^ address) so every word is traceable.
module tb_instruction_prefetch_queue;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    instruction_prefetch_queue_if #(.DEPTH(4)) bus ();

    instruction_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data is a fixed function of the requested address
    assign bus.memData = 32'hC0DE_0000 ^ bus.memAddr;

    // Compare one observed value against a hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock cycle, returning at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold the design in reset for two cycles with quiet inputs
    task automatic applyStimulus(input logic ack, input logic hld);
        rst_n            = 1'b0;
        bus.memAck       = ack;
        bus.hold         = hld;
        bus.redirect     = 1'b0;
        bus.redirectAddr = 32'h0;
        step();
        step();
    endtask

    // Directed test sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        @(negedge clk);

        // ---- Reset state and streaming with memAck tied high ----
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst memReq",      32'(bus.memReq),     32'h0);
        checkOutput("rst memAddr",     bus.memAddr,         32'h0);
        checkOutput("rst count",       32'(bus.count),      32'h0);
        checkOutput("rst instrValid",  32'(bus.instrValid), 32'h0);
        checkOutput("rst instruction", bus.instruction,     32'h0);
        checkOutput("rst pcPlus4",     bus.pcPlus4,         32'h0);
        bus.memAck = 1'b1;
        rst_n      = 1'b1;
        checkOutput("s c0 memReq", 32'(bus.memReq), 32'h0);
        step();
        checkOutput("s c1 memReq",     32'(bus.memReq),     32'h1);
        checkOutput("s c1 memAddr",    bus.memAddr,         32'h0);
        checkOutput("s c1 instrValid", 32'(bus.instrValid), 32'h0);
        step();
        checkOutput("s c2 instrValid",  32'(bus.instrValid), 32'h1);
        checkOutput("s c2 instruction", bus.instruction,     32'hC0DE_0000);
        checkOutput("s c2 pcPlus4",     bus.pcPlus4,         32'h4);
        checkOutput("s c2 memAddr",     bus.memAddr,         32'h4);
        step();
        checkOutput("s c3 instruction", bus.instruction, 32'hC0DE_0004);
        checkOutput("s c3 pcPlus4",     bus.pcPlus4,     32'h8);
        checkOutput("s c3 count",       32'(bus.count),  32'h1);
        step();
        checkOutput("s c4 pcPlus4", bus.pcPlus4, 32'hC);

        // ---- Fill under hold, then release for one cycle ----
        applyStimulus(1'b1, 1'b1);
        rst_n = 1'b1;
        step();
        step();
        step();
        step();
        checkOutput("h c4 count",   32'(bus.count),  32'h3);
        checkOutput("h c4 memAddr", bus.memAddr,     32'hC);
        step();
        checkOutput("h c5 count",   32'(bus.count),  32'h4);
        checkOutput("h c5 memReq",  32'(bus.memReq), 32'h0);
        checkOutput("h c5 pcPlus4", bus.pcPlus4,     32'h4);
        step();
        checkOutput("h c6 memReq",  32'(bus.memReq), 32'h0);
        checkOutput("h c6 memAddr", bus.memAddr,     32'hC);
        bus.hold = 1'b0;
        step();
        bus.hold = 1'b1;
        checkOutput("h c7 memReq",  32'(bus.memReq), 32'h1);
        checkOutput("h c7 memAddr", bus.memAddr,     32'h10);
        checkOutput("h c7 count",   32'(bus.count),  32'h3);
        checkOutput("h c7 pcPlus4", bus.pcPlus4,     32'h8);
        step();
        checkOutput("h c8 count",  32'(bus.count),  32'h4);
        checkOutput("h c8 memReq", 32'(bus.memReq), 32'h0);

        // ---- Redirect while the acknowledge is late ----
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        checkOutput("d c1 memReq", 32'(bus.memReq), 32'h1);
        bus.redirect     = 1'b1;
        bus.redirectAddr = 32'h40;
        step();
        bus.redirect = 1'b0;
        checkOutput("d c2 memReq",     32'(bus.memReq),     32'h1);
        checkOutput("d c2 memAddr",    bus.memAddr,         32'h0);
        checkOutput("d c2 instrValid", 32'(bus.instrValid), 32'h0);
        step();
        checkOutput("d c3 memReq", 32'(bus.memReq), 32'h1);
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        checkOutput("d c5 memReq",     32'(bus.memReq),     32'h0);
        checkOutput("d c5 count",      32'(bus.count),      32'h0);
        checkOutput("d c5 instrValid", 32'(bus.instrValid), 32'h0);
        step();
        checkOutput("d c6 memReq",  32'(bus.memReq), 32'h1);
        checkOutput("d c6 memAddr", bus.memAddr,     32'h40);
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        checkOutput("d c7 instruction", bus.instruction, 32'hC0DE_0040);
        checkOutput("d c7 pcPlus4",     bus.pcPlus4,     32'h44);

        // ---- Redirect coincident with acknowledge and pop at count 2 ----
        applyStimulus(1'b1, 1'b1);
        rst_n = 1'b1;
        step();
        step();
        step();
        checkOutput("r c3 count",   32'(bus.count), 32'h2);
        checkOutput("r c3 memAddr", bus.memAddr,    32'h8);
        bus.hold         = 1'b0;
        bus.redirect     = 1'b1;
        bus.redirectAddr = 32'h40;
        step();
        bus.redirect = 1'b0;
        checkOutput("r c4 count",       32'(bus.count),      32'h0);
        checkOutput("r c4 instrValid",  32'(bus.instrValid), 32'h0);
        checkOutput("r c4 instruction", bus.instruction,     32'h0);
        checkOutput("r c4 memReq",      32'(bus.memReq),     32'h0);
        step();
        checkOutput("r c5 memReq",  32'(bus.memReq), 32'h1);
        checkOutput("r c5 memAddr", bus.memAddr,     32'h40);
        bus.hold = 1'b1;
        step();
        checkOutput("r c6 instruction", bus.instruction, 32'hC0DE_0040);
        checkOutput("r c6 pcPlus4",     bus.pcPlus4,     32'h44);
        checkOutput("r c6 count",       32'(bus.count),  32'h1);

        // ---- Misaligned redirect issued while idle ----
        applyStimulus(1'b0, 1'b1);
        rst_n            = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirectAddr = 32'h43;
        step();
        bus.redirect = 1'b0;
        checkOutput("m c1 memReq", 32'(bus.memReq), 32'h0);
        step();
        checkOutput("m c2 memReq",  32'(bus.memReq), 32'h1);
        checkOutput("m c2 memAddr", bus.memAddr,     32'h40);
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        checkOutput("m c3 pcPlus4",     bus.pcPlus4,     32'h44);
        checkOutput("m c3 instruction", bus.instruction, 32'hC0DE_0040);

        // ---- Address wrap at the top of memory ----
        applyStimulus(1'b1, 1'b1);
        rst_n            = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirectAddr = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        step();
        checkOutput("w c2 memAddr", bus.memAddr, 32'hFFFF_FFFC);
        step();
        checkOutput("w c3 pcPlus4",     bus.pcPlus4,     32'h0);
        checkOutput("w c3 instruction", bus.instruction, 32'h3F21_FFFC);
        checkOutput("w c3 memAddr",     bus.memAddr,     32'h0);
        step();
        checkOutput("w c4 count",   32'(bus.count), 32'h2);
        checkOutput("w c4 pcPlus4", bus.pcPlus4,    32'h0);

        // ---- Asynchronous reset in the middle of a request ----
        applyStimulus(1'b0, 1'b1);
        rst_n      = 1'b1;
        bus.memAck = 1'b1;
        step();
        step();
        bus.memAck = 1'b0;
        checkOutput("a c2 count",  32'(bus.count),  32'h1);
        checkOutput("a c2 memReq", 32'(bus.memReq), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("a async memReq",     32'(bus.memReq),     32'h0);
        checkOutput("a async count",      32'(bus.count),      32'h0);
        checkOutput("a async instrValid", 32'(bus.instrValid), 32'h0);
        checkOutput("a async memAddr",    bus.memAddr,         32'h0);
        @(negedge clk);
        bus.memAck = 1'b1;
        step();
        step();
        checkOutput("a inrst count", 32'(bus.count), 32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("a c1 count",   32'(bus.count),  32'h0);
        checkOutput("a c1 memReq",  32'(bus.memReq), 32'h1);
        checkOutput("a c1 memAddr", bus.memAddr,     32'h0);
        bus.memAck = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
